// File: rtl/multi_gate_lot_counter.sv
// Multi-gate parking lot occupancy counter: per-gate direction FSMs feed one
// saturating occupancy count with BCD digits, full/empty and sticky error flags.
module multi_gate_lot_counter #(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 16,
  parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  input  logic                 clear_err,
  output logic [CNT_W-1:0]     count,
  output logic [3:0]           bcd_hun,
  output logic [3:0]           bcd_ten,
  output logic [3:0]           bcd_one,
  output logic                 full,
  output logic                 empty,
  output logic                 err_over,
  output logic                 err_under,
  output logic [NUM_GATES-1:0] enter_evt,
  output logic [NUM_GATES-1:0] exit_evt
);

  typedef enum logic [2:0] {
    S_IDLE, S_EN1, S_EN2, S_EN3, S_EX1, S_EX2, S_EX3
  } gate_state_e;

  localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W + 4)'(CAPACITY);
  localparam logic [CNT_W-1:0]        CAP_C = CNT_W'(CAPACITY);

  gate_state_e          state_q [NUM_GATES];
  gate_state_e          state_d [NUM_GATES];
  logic [NUM_GATES-1:0] enter_evt_q, enter_evt_d;
  logic [NUM_GATES-1:0] exit_evt_q, exit_evt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [3:0]           bcd_hun_q, bcd_hun_d;
  logic [3:0]           bcd_ten_q, bcd_ten_d;
  logic [3:0]           bcd_one_q, bcd_one_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 err_over_q, err_over_d;
  logic                 err_under_q, err_under_d;

  logic [1:0]              sens;
  logic [3:0]              n_in, n_out;
  logic signed [CNT_W+3:0] raw;
  logic [9:0]              cnt_ext, hun_w, ten_w, one_w;

  // Gate FSMs: exit states mirror entry states with outer/inner swapped.
  always_comb begin
    sens        = '0;
    enter_evt_d = '0;
    exit_evt_d  = '0;
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      state_d[g] = state_q[g];
      sens       = {outer[g], inner[g]};
      case (state_q[g])
        S_IDLE: begin
          if (sens == 2'b10)      state_d[g] = S_EN1;
          else if (sens == 2'b01) state_d[g] = S_EX1;
        end
        S_EN1: begin
          if (sens == 2'b11)      state_d[g] = S_EN2;
          else if (sens != 2'b10) state_d[g] = S_IDLE;
        end
        S_EN2: begin
          case (sens)
            2'b01:   state_d[g] = S_EN3;
            2'b10:   state_d[g] = S_EN1;
            2'b00:   state_d[g] = S_IDLE;
            default: state_d[g] = S_EN2;
          endcase
        end
        S_EN3: begin
          case (sens)
            2'b00: begin
              state_d[g]     = S_IDLE;
              enter_evt_d[g] = 1'b1;
            end
            2'b11:   state_d[g] = S_EN2;
            2'b10:   state_d[g] = S_IDLE;
            default: state_d[g] = S_EN3;
          endcase
        end
        S_EX1: begin
          if (sens == 2'b11)      state_d[g] = S_EX2;
          else if (sens != 2'b01) state_d[g] = S_IDLE;
        end
        S_EX2: begin
          case (sens)
            2'b10:   state_d[g] = S_EX3;
            2'b01:   state_d[g] = S_EX1;
            2'b00:   state_d[g] = S_IDLE;
            default: state_d[g] = S_EX2;
          endcase
        end
        S_EX3: begin
          case (sens)
            2'b00: begin
              state_d[g]    = S_IDLE;
              exit_evt_d[g] = 1'b1;
            end
            2'b11:   state_d[g] = S_EX2;
            2'b01:   state_d[g] = S_IDLE;
            default: state_d[g] = S_EX3;
          endcase
        end
        default: state_d[g] = S_IDLE;
      endcase
    end
  end

  // Occupancy update: net all gate events, then saturate at 0 / CAPACITY.
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      n_in  = n_in  + {3'b000, enter_evt_q[g]};
      n_out = n_out + {3'b000, exit_evt_q[g]};
    end
    raw = $signed({4'b0000, count_q}) + $signed({{CNT_W{1'b0}}, n_in})
        - $signed({{CNT_W{1'b0}}, n_out});

    count_d     = count_q;
    err_over_d  = clear_err ? 1'b0 : err_over_q;
    err_under_d = clear_err ? 1'b0 : err_under_q;
    if (raw > CAP_S) begin
      count_d    = CAP_C;
      err_over_d = 1'b1;
    end else if (raw < 0) begin
      count_d     = '0;
      err_under_d = 1'b1;
    end else begin
      count_d = raw[CNT_W-1:0];
    end
  end

  always_comb begin
    cnt_ext   = 10'(count_q);
    hun_w     = cnt_ext / 10'd100;
    ten_w     = (cnt_ext / 10'd10) % 10'd10;
    one_w     = cnt_ext % 10'd10;
    bcd_hun_d = hun_w[3:0];
    bcd_ten_d = ten_w[3:0];
    bcd_one_d = one_w[3:0];
    full_d    = (count_q == CAP_C);
    empty_d   = (count_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned g = 0; g < NUM_GATES; g++) state_q[g] <= S_IDLE;
      enter_evt_q <= '0;
      exit_evt_q  <= '0;
      count_q     <= '0;
      bcd_hun_q   <= '0;
      bcd_ten_q   <= '0;
      bcd_one_q   <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      for (int unsigned g = 0; g < NUM_GATES; g++) state_q[g] <= state_d[g];
      enter_evt_q <= enter_evt_d;
      exit_evt_q  <= exit_evt_d;
      count_q     <= count_d;
      bcd_hun_q   <= bcd_hun_d;
      bcd_ten_q   <= bcd_ten_d;
      bcd_one_q   <= bcd_one_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

  assign count     = count_q;
  assign bcd_hun   = bcd_hun_q;
  assign bcd_ten   = bcd_ten_q;
  assign bcd_one   = bcd_one_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err_over  = err_over_q;
  assign err_under = err_under_q;
  assign enter_evt = enter_evt_q;
  assign exit_evt  = exit_evt_q;

endmodule

// File: tb/tb_multi_gate_lot_counter.sv
// Directed bench for multi_gate_lot_counter: a CAPACITY=16 and a CAPACITY=150
// instance share stimulus; expected values are queued and checked after settling.
module tb_multi_gate_lot_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] outer = '0;
  logic [1:0] inner = '0;
  logic       clear_err = 1'b0;

  logic [4:0] count_a;
  logic [3:0] hun_a, ten_a, one_a;
  logic       full_a, empty_a, eo_a, eu_a;
  logic [1:0] en_a, ex_a;

  logic [7:0] count_b;
  logic [3:0] hun_b, ten_b, one_b;
  logic       full_b, empty_b, eo_b, eu_b;
  logic [1:0] en_b, ex_b;

  multi_gate_lot_counter #(.NUM_GATES(2), .CAPACITY(16)) dut (
    .clk(clk), .reset(reset), .outer(outer), .inner(inner), .clear_err(clear_err),
    .count(count_a), .bcd_hun(hun_a), .bcd_ten(ten_a), .bcd_one(one_a),
    .full(full_a), .empty(empty_a), .err_over(eo_a), .err_under(eu_a),
    .enter_evt(en_a), .exit_evt(ex_a));

  multi_gate_lot_counter #(.NUM_GATES(2), .CAPACITY(150)) dut150 (
    .clk(clk), .reset(reset), .outer(outer), .inner(inner), .clear_err(clear_err),
    .count(count_b), .bcd_hun(hun_b), .bcd_ten(ten_b), .bcd_one(one_b),
    .full(full_b), .empty(empty_b), .err_over(eo_b), .err_under(eu_b),
    .enter_evt(en_b), .exit_evt(ex_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters observed on the falling edge, away from the active edge.
  int en_seen0 = 0, en_seen1 = 0, ex_seen0 = 0, ex_seen1 = 0;
  always @(negedge clk) begin
    if (!reset) begin
      en_seen0 += int'(en_a[0]);
      en_seen1 += int'(en_a[1]);
      ex_seen0 += int'(ex_a[0]);
      ex_seen1 += int'(ex_a[1]);
    end
  end

  // Reference model state.
  int exp16 = 0, exp150 = 0;
  int exp_eo = 0, exp_eu = 0;
  int exp_en0 = 0, exp_en1 = 0, exp_ex0 = 0, exp_ex1 = 0;

  string tag_q[$];
  int    exp_q[$];

  task automatic step(input logic [1:0] o, input logic [1:0] i);
    outer = o;
    inner = i;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int nin, input int nout);
    int r;
    r = exp16 + nin - nout;
    if (r > 16)      begin exp16 = 16; exp_eo = 1; end
    else if (r < 0)  begin exp16 = 0;  exp_eu = 1; end
    else             exp16 = r;
    r = exp150 + nin - nout;
    if (r > 150)     exp150 = 150;
    else if (r < 0)  exp150 = 0;
    else             exp150 = r;
  endtask

  task automatic enter_g(input logic [1:0] m);
    step(m, 2'b00); step(m, m); step(2'b00, m); step(2'b00, 2'b00);
    apply((m[0] ? 1 : 0) + (m[1] ? 1 : 0), 0);
    if (m[0]) exp_en0++;
    if (m[1]) exp_en1++;
  endtask

  task automatic exit_g(input logic [1:0] m);
    step(2'b00, m); step(m, m); step(m, 2'b00); step(2'b00, 2'b00);
    apply(0, (m[0] ? 1 : 0) + (m[1] ? 1 : 0));
    if (m[0]) exp_ex0++;
    if (m[1]) exp_ex1++;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step(2'b00, 2'b00);
    clear_err = 1'b0;
    exp_eo = 0;
    exp_eu = 0;
  endtask

  task automatic push(input string t, input int v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic push_status();
    int hun, ten, one;
    hun = exp16 / 100;
    ten = (exp16 / 10) % 10;
    one = exp16 % 10;
    push("count", exp16);
    push("bcd_hun", hun);
    push("bcd_ten", ten);
    push("bcd_one", one);
    push("full", (exp16 == 16) ? 1 : 0);
    push("empty", (exp16 == 0) ? 1 : 0);
    push("err_over", exp_eo);
    push("err_under", exp_eu);
    push("enter0", exp_en0);
    push("enter1", exp_en1);
    push("exit0", exp_ex0);
    push("exit1", exp_ex1);
  endtask

  function automatic int observe(input string t);
    case (t)
      "count":     return int'(count_a);
      "bcd_hun":   return int'(hun_a);
      "bcd_ten":   return int'(ten_a);
      "bcd_one":   return int'(one_a);
      "full":      return int'(full_a);
      "empty":     return int'(empty_a);
      "err_over":  return int'(eo_a);
      "err_under": return int'(eu_a);
      "enter0":    return en_seen0;
      "enter1":    return en_seen1;
      "exit0":     return ex_seen0;
      "exit1":     return ex_seen1;
      "c150":      return int'(count_b);
      "c150_hun":  return int'(hun_b);
      "c150_ten":  return int'(ten_b);
      "c150_one":  return int'(one_b);
      default:     return -1;
    endcase
  endfunction

  // Two idle cycles cover event -> count -> BCD/flag latency.
  task automatic settle_and_check(input int idle);
    string t;
    int    e;
    int    o;
    for (int k = 0; k < idle; k++) step(2'b00, 2'b00);
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      o = observe(t);
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", t, o, e);
      end
    end
  endtask

  initial begin
    // Reset state
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    push_status();
    settle_and_check(0);
    reset = 1'b0;

    // Single entry on gate 0
    enter_g(2'b01);
    push_status();
    settle_and_check(2);

    // Bring count to 5, then exit on gate 1
    enter_g(2'b11);
    enter_g(2'b11);
    exit_g(2'b10);
    push_status();
    settle_and_check(2);

    // Gate 0 enters then backs out: no event
    step(2'b01, 2'b00); step(2'b01, 2'b01); step(2'b01, 2'b00); step(2'b00, 2'b00);
    push_status();
    settle_and_check(2);

    // Fill to capacity
    for (int k = 0; k < 6; k++) enter_g(2'b11);
    push_status();
    settle_and_check(2);

    // One more entry at capacity -> saturate and flag
    enter_g(2'b01);
    push_status();
    settle_and_check(2);
    pulse_clear();
    push_status();
    settle_and_check(2);

    // Drain to zero, then underflow on gate 0
    for (int k = 0; k < 8; k++) exit_g(2'b11);
    push_status();
    settle_and_check(2);
    exit_g(2'b01);
    push_status();
    settle_and_check(2);

    // Count to 3, then simultaneous entry gate 0 / exit gate 1 nets out
    pulse_clear();
    enter_g(2'b11);
    enter_g(2'b01);
    step(2'b01, 2'b10); step(2'b11, 2'b11); step(2'b10, 2'b01); step(2'b00, 2'b00);
    apply(1, 1);
    exp_en0++;
    exp_ex1++;
    push_status();
    settle_and_check(2);

    // Reset while gate 0 is in EN2; the remaining 01,00 must not complete an entry
    step(2'b01, 2'b00); step(2'b01, 2'b01);
    reset = 1'b1;
    step(2'b01, 2'b01);
    reset = 1'b0;
    exp16 = 0; exp150 = 0; exp_eo = 0; exp_eu = 0;
    step(2'b00, 2'b01); step(2'b00, 2'b00);
    push_status();
    settle_and_check(2);

    // Drive the CAPACITY=150 instance to 123
    for (int k = 0; k < 61; k++) enter_g(2'b11);
    enter_g(2'b01);
    push("c150", exp150);
    push("c150_hun", exp150 / 100);
    push("c150_ten", (exp150 / 10) % 10);
    push("c150_one", exp150 % 10);
    push_status();
    settle_and_check(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
